// File: rtl/pcie_axil_regfile_pkg.sv
// pcie_regfile_pkg: shared constants and types for the PCIe AXI-Lite register file.
//   - Byte offsets of the register map (decoded on addr[11:2]).
//   - AXI response codes and the read-back pattern for unmapped offsets.
//   - Write/read channel FSM state types.
//   - Byte-strobe merge helper.
package pcie_regfile_pkg;

  localparam logic [11:0] OFF_ID        = 12'h000;
  localparam logic [11:0] OFF_SCRATCH   = 12'h004;
  localparam logic [11:0] OFF_CTRL_BASE = 12'h010;
  localparam logic [11:0] OFF_STAT_BASE = 12'h100;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  function automatic logic [9:0] word_idx(input logic [11:0] off);
    return off[11:2];
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pcie_axil_regfile_if.sv
// pcie_axil_regfile_if: 32-bit AXI-Lite bus between the PCIe bridge master port
// and the register file.
//   slave  modport: used by the register file (AW/W/AR/B/R in slave direction).
//   master modport: used by the bridge side (or a testbench).
interface pcie_axil_regfile_if;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  modport slave (
    input  AWADDR, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );

  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );
endinterface

// File: rtl/pcie_axil_regfile_counter.sv
// pcie_regfile_counter: one saturating event counter.
//   clk, rst   : clock, asynchronous active-high reset
//   inc        : one-cycle increment pulse
//   clr        : clear from a register write commit
//   snap_clr   : clear from a read snapshot (clear-on-read builds)
//   cnt        : current count, saturates at all-ones
module pcie_regfile_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             snap_clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || snap_clr) begin
      // An event landing on the clear edge is kept rather than lost.
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pcie_axil_regfile.sv
// pcie_axil_regfile: AXI-Lite slave register file on the PCIe bridge master port.
//   axi_clk, axi_reset : PCIe user clock, asynchronous active-high reset
//   pcie_axi           : AXI-Lite slave port (pcie_axil_regfile_if.slave)
//   ctrl_out           : NUM_CTRL control registers, reg i at [32i+31:32i]
//   stat_evt           : one-cycle increment pulses, one per event counter
// Map (addr[11:2] decoded): 0x000 ID (RO), 0x004 scratch, 0x010+4i control,
// 0x100+4i counter (write clears). Unmapped: DEAD_BEEF / SLVERR.
// Build option: PCIE_REGFILE_CLEAR_ON_READ_EN makes counter reads destructive.
module pcie_axil_regfile
  import pcie_regfile_pkg::*;
#(
  parameter int unsigned NUM_CTRL = 4,
  parameter int unsigned NUM_STAT = 4,
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] ID_VALUE = 32'h4D43_0001
) (
  input  logic                    axi_clk,
  input  logic                    axi_reset,
  pcie_axil_regfile_if.slave      pcie_axi,
  output logic [32*NUM_CTRL-1:0]  ctrl_out,
  input  logic [NUM_STAT-1:0]     stat_evt
);

  localparam logic [9:0] IDX_ID      = word_idx(OFF_ID);
  localparam logic [9:0] IDX_SCRATCH = word_idx(OFF_SCRATCH);
  localparam logic [9:0] IDX_CTRL    = word_idx(OFF_CTRL_BASE);
  localparam logic [9:0] IDX_STAT    = word_idx(OFF_STAT_BASE);

  wr_state_t w_state;
  rd_state_t r_state;

  logic        aw_held, w_held;
  logic [9:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  logic [31:0]      scratch_q;
  logic [31:0]      ctrl_q [NUM_CTRL];
  logic [CNT_W-1:0] cnt    [NUM_STAT];

  logic                wr_commit, wr_scratch_hit, wr_err;
  logic [NUM_CTRL-1:0] wr_ctrl_hit;
  logic [NUM_STAT-1:0] wr_stat_hit;

  logic [9:0]          rd_idx;
  logic [31:0]         rd_data;
  logic                rd_err, ar_hs;
  logic [NUM_STAT-1:0] rd_stat_hit, snap_clr;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{pcie_axi.AWADDR[31:12], pcie_axi.AWADDR[1:0],
                              pcie_axi.ARADDR[31:12], pcie_axi.ARADDR[1:0]};

  // ---------------- write decode ----------------
  always_comb begin
    wr_commit      = (w_state == W_IDLE) && aw_held && w_held;
    wr_scratch_hit = (aw_idx == IDX_SCRATCH);
    wr_ctrl_hit    = '0;
    wr_stat_hit    = '0;
    for (int unsigned i = 0; i < NUM_CTRL; i++)
      wr_ctrl_hit[i] = (aw_idx == IDX_CTRL + 10'(i));
    for (int unsigned i = 0; i < NUM_STAT; i++)
      wr_stat_hit[i] = (aw_idx == IDX_STAT + 10'(i));
    wr_err = (aw_idx == IDX_ID) ||
             !(wr_scratch_hit || (|wr_ctrl_hit) || (|wr_stat_hit));
  end

  // ---------------- write channel FSM ----------------
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      w_state          <= W_IDLE;
      aw_held          <= 1'b0;
      w_held           <= 1'b0;
      aw_idx           <= '0;
      w_data           <= '0;
      w_strb           <= '0;
      pcie_axi.AWREADY <= 1'b0;
      pcie_axi.WREADY  <= 1'b0;
      pcie_axi.BVALID  <= 1'b0;
      pcie_axi.BRESP   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_commit) begin
            pcie_axi.BVALID  <= 1'b1;
            pcie_axi.BRESP   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            pcie_axi.AWREADY <= 1'b0;
            pcie_axi.WREADY  <= 1'b0;
            w_state          <= W_RESP;
          end else begin
            if (pcie_axi.AWVALID && pcie_axi.AWREADY) begin
              aw_held <= 1'b1;
              aw_idx  <= pcie_axi.AWADDR[11:2];
            end
            if (pcie_axi.WVALID && pcie_axi.WREADY) begin
              w_held <= 1'b1;
              w_data <= pcie_axi.WDATA;
              w_strb <= pcie_axi.WSTRB;
            end
            // Registered READY tracks !held, dropping on the capture edge.
            pcie_axi.AWREADY <= !(aw_held || (pcie_axi.AWVALID && pcie_axi.AWREADY));
            pcie_axi.WREADY  <= !(w_held  || (pcie_axi.WVALID  && pcie_axi.WREADY));
          end
        end
        W_RESP: begin
          if (pcie_axi.BREADY) begin
            pcie_axi.BVALID  <= 1'b0;
            aw_held          <= 1'b0;
            w_held           <= 1'b0;
            pcie_axi.AWREADY <= 1'b1;
            pcie_axi.WREADY  <= 1'b1;
            w_state          <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- RW registers ----------------
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      scratch_q <= '0;
      for (int unsigned i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
    end else if (wr_commit) begin
      if (wr_scratch_hit) scratch_q <= apply_wstrb(scratch_q, w_data, w_strb);
      for (int unsigned i = 0; i < NUM_CTRL; i++)
        if (wr_ctrl_hit[i]) ctrl_q[i] <= apply_wstrb(ctrl_q[i], w_data, w_strb);
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
    assign ctrl_out[32*g +: 32] = ctrl_q[g];
  end

  // ---------------- read decode ----------------
  assign rd_idx = pcie_axi.ARADDR[11:2];
  assign ar_hs  = (r_state == R_IDLE) && pcie_axi.ARVALID && pcie_axi.ARREADY;

  always_comb begin
    rd_data     = DEAD_BEEF;
    rd_err      = 1'b1;
    rd_stat_hit = '0;
    if (rd_idx == IDX_ID) begin
      rd_data = ID_VALUE;
      rd_err  = 1'b0;
    end
    if (rd_idx == IDX_SCRATCH) begin
      rd_data = scratch_q;
      rd_err  = 1'b0;
    end
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      if (rd_idx == IDX_CTRL + 10'(i)) begin
        rd_data = ctrl_q[i];
        rd_err  = 1'b0;
      end
    end
    for (int unsigned i = 0; i < NUM_STAT; i++) begin
      if (rd_idx == IDX_STAT + 10'(i)) begin
        rd_data        = 32'(cnt[i]);
        rd_err         = 1'b0;
        rd_stat_hit[i] = 1'b1;
      end
    end
  end

  // ---------------- read channel FSM ----------------
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state          <= R_IDLE;
      pcie_axi.ARREADY <= 1'b0;
      pcie_axi.RVALID  <= 1'b0;
      pcie_axi.RDATA   <= '0;
      pcie_axi.RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            pcie_axi.RDATA   <= rd_data;
            pcie_axi.RRESP   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            pcie_axi.RVALID  <= 1'b1;
            pcie_axi.ARREADY <= 1'b0;
            r_state          <= R_RESP;
          end else begin
            pcie_axi.ARREADY <= 1'b1;
          end
        end
        R_RESP: begin
          if (pcie_axi.RREADY) begin
            pcie_axi.RVALID  <= 1'b0;
            pcie_axi.ARREADY <= 1'b1;
            r_state          <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- event counters ----------------
`ifdef PCIE_REGFILE_CLEAR_ON_READ_EN
  assign snap_clr = ar_hs ? rd_stat_hit : '0;
`else
  logic unused_rd_stat_hit;
  assign unused_rd_stat_hit = |rd_stat_hit;
  assign snap_clr = '0;
`endif

  for (genvar g = 0; g < NUM_STAT; g++) begin : g_cnt
    pcie_regfile_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (axi_clk),
      .rst      (axi_reset),
      .inc      (stat_evt[g]),
      .clr      (wr_commit && wr_stat_hit[g]),
      .snap_clr (snap_clr[g]),
      .cnt      (cnt[g])
    );
  end

endmodule

// File: doc/pcie_axil_regfile.md
Name: pcie_axil_regfile

Overview:
- AXI-Lite slave register file on the 32-bit master port of the PCIe-to-AXI-Lite bridge, in the PCIe user-clock domain.
- Gives host software an ID register, a scratch register, NUM_CTRL control registers driven out to the memcached pipeline, and NUM_STAT saturating event counters.
- Single outstanding transaction per channel; read and write channels run independently.

Parameters:
- NUM_CTRL, 4, number of RW control registers (1..16).
- NUM_STAT, 4, number of RO event counters (1..32).
- CNT_W, 32, counter width (1..32); reads zero-extend to 32 bits.
- ID_VALUE, 32'h4D43_0001, value returned at offset 0x000.

Ports:
- axi_clk  in  1  PCIe user clock.
- axi_reset  in  1  asynchronous, active-high reset.
- pcie_axi_AWADDR  in  32  write address.
- pcie_axi_AWVALID  in  1  write address valid.
- pcie_axi_AWREADY  out  1  write address ready.
- pcie_axi_WDATA  in  32  write data.
- pcie_axi_WSTRB  in  4  byte strobes.
- pcie_axi_WVALID  in  1  write data valid.
- pcie_axi_WREADY  out  1  write data ready.
- pcie_axi_BRESP  out  2  write response.
- pcie_axi_BVALID  out  1  write response valid.
- pcie_axi_BREADY  in  1  write response ready.
- pcie_axi_ARADDR  in  32  read address.
- pcie_axi_ARVALID  in  1  read address valid.
- pcie_axi_ARREADY  out  1  read address ready.
- pcie_axi_RDATA  out  32  read data.
- pcie_axi_RRESP  out  2  read response.
- pcie_axi_RVALID  out  1  read data valid.
- pcie_axi_RREADY  in  1  read data ready.
- ctrl_out  out  32*NUM_CTRL  flattened control registers; reg i occupies bits [32i+31:32i].
- stat_evt  in  NUM_STAT  one-cycle increment pulses, one per counter.

Behaviour:
- Clocking and reset: one clock domain, axi_clk. Reset is asynchronous and active-high on axi_reset.
- Reset values: all outputs, registers and counters are 0. READY outputs are 0 while in reset and rise on the first axi_clk edge after axi_reset is released.
- Address decode uses addr[11:2]; bits [31:12] and [1:0] are ignored.
  - 0x000: ID register, RO.
  - 0x004: scratch register, RW.
  - 0x010+4i: control register i, RW, for i < NUM_CTRL.
  - 0x100+4i: counter i, for i < NUM_STAT. A write of any data clears the counter.
  - Any other offset is unmapped: a read returns 32'hDEAD_BEEF with SLVERR (2'b10); a write has no effect and returns SLVERR.
  - A write to the ID register returns SLVERR.
  - All other accesses return OKAY (2'b00).
- Write path, states W_IDLE and W_RESP:
  - W_IDLE: AWREADY = !aw_held and WREADY = !w_held. AW and W are captured independently, in either order or in the same cycle.
  - The cycle after both are held, the write commits, honouring WSTRB per byte (counter clear ignores WSTRB). In the same edge BVALID rises, both READYs drop, and the FSM enters W_RESP.
  - W_RESP: hold BVALID/BRESP until BREADY; then clear the held flags and return to W_IDLE.
- Read path, states R_IDLE and R_RESP:
  - R_IDLE: ARREADY = 1. On handshake, register RDATA/RRESP and assert RVALID on the next edge (1-cycle latency). ARREADY drops.
  - R_RESP: hold RDATA/RRESP/RVALID stable until RREADY; return to R_IDLE. ARREADY rises again the cycle after the RVALID&RREADY handshake.
- Counters:
  - Increment by 1 on stat_evt[i]; saturate at all-ones with no wrap.
  - A read samples the pre-increment value at the AR handshake edge.
  - A clear coincident with an event leaves the counter at 1 (event not lost).
- A simultaneous read and write to the same register returns the old value.
- ctrl_out updates on the commit edge.

Optional Feature:
- Macro: PCIE_REGFILE_CLEAR_ON_READ_EN.
- Defined: a read of counter i clears it on the AR handshake edge (the read still returns the old value); coincident-event rule as above.
- Undefined: reads are non-destructive; counters clear only by write or reset.

Decomposition:
- Package pcie_regfile_pkg holds:
  - offset constants: OFF_ID, OFF_SCRATCH, OFF_CTRL_BASE, OFF_STAT_BASE;
  - RESP_OKAY and RESP_SLVERR;
  - the DEAD_BEEF constant;
  - write/read FSM state typedefs.
- One sub-module: pcie_regfile_counter (single saturating counter with inc, clr, snapshot-clear), instantiated NUM_STAT times.

Test Plan:
1. Release reset, read 0x000 -> AR handshake, RVALID 1 cycle later, RDATA=32'h4D43_0001, RRESP=00; all outputs were 0 during reset.
2. Write 0x010 with data 32'hA5A5_A5A5, WSTRB=4'b0101, W presented 3 cycles before AW -> BRESP=00; ctrl_out[31:0]=32'h00A5_00A5; read-back matches.
3. Write to 0x0F0, and separately read 0x0F0 -> BRESP=10; RDATA=32'hDEAD_BEEF, RRESP=10; no register changes.
4. With CNT_W=4, pulse stat_evt[0] 20 times -> read 0x100 returns 15; write 0x100 -> reads 0; write coincident with a pulse -> reads 1.
5. Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stay stable; AWREADY/WREADY/ARREADY stay 0.
6. With PCIE_REGFILE_CLEAR_ON_READ_EN defined, counter at 7: first read returns 7, second returns 0. Undefined: both return 7. Assert axi_reset mid-W_RESP -> BVALID drops immediately.
